instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit.sv | 86 ++++++++
 tb/tb_instruction_fetch_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch stage bus: redirect inputs, instruction memory port, decode handshake
interface instruction_fetch_unit_if #(
    parameter int Width = 32
) ();
    logic [1:0]       pc_src;
    logic [Width-1:0] branch_target;
    logic [Width-1:0] mepc;
    logic [Width-1:0] sepc;
    logic             mem_rd_en;
    logic [Width-1:0] mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rd_dat;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instruction;
    logic [Width-1:0] instr_pc;

    modport master (
        input  pc_src, branch_target, mepc, sepc, mem_ack, mem_rd_dat, instr_ready,
        output mem_rd_en, mem_addr, instr_valid, instruction, instr_pc
    );

    modport slave (
        output pc_src, branch_target, mepc, sepc, mem_ack, mem_rd_dat, instr_ready,
        input  mem_rd_en, mem_addr, instr_valid, instruction, instr_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, instruction memory requester and one-entry output register
module instruction_fetch_unit #(
    parameter int               Width       = 32,
    parameter logic [Width-1:0] ResetVector = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t           state_q;
    logic [Width-1:0] pc_q;
    logic [Width-1:0] pc_d;
    logic [Width-1:0] stale_addr_q;
    logic [Width-1:0] instr_pc_q;
    logic [31:0]      instruction_q;
    logic [Width-1:0] redirect_target;
    logic             redirect;

    always_comb begin
        redirect        = (bus.pc_src != 2'b00);
        redirect_target = bus.branch_target;
        case (bus.pc_src)
            2'b01:   redirect_target = bus.mepc;
            2'b10:   redirect_target = bus.sepc;
            default: redirect_target = bus.branch_target;
        endcase
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_target[Width-1:2], 2'b00};
        end else if ((state_q == ST_FETCH) && bus.mem_ack) begin
            pc_d = pc_q + Width'(4);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= ResetVector;
            stale_addr_q  <= ResetVector;
            instr_pc_q    <= ResetVector;
            instruction_q <= 32'h0000_0013;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (redirect) begin
                        // An unacked request must still be drained, so remember its address.
                        stale_addr_q <= pc_q;
                        state_q      <= bus.mem_ack ? ST_FETCH : ST_DROP;
                    end else if (bus.mem_ack) begin
                        instruction_q <= bus.mem_rd_dat;
                        instr_pc_q    <= pc_q;
                        state_q       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect || bus.instr_ready) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (bus.mem_ack) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en   = (state_q == ST_FETCH) || (state_q == ST_DROP);
    assign bus.mem_addr    = (state_q == ST_DROP) ? stale_addr_q : pc_q;
    assign bus.instr_valid = (state_q == ST_HOLD);
    assign bus.instruction = instruction_q;
    assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized and directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_1000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.Width(W)) bus ();

    instruction_fetch_unit #(.Width(W), .ResetVector(RV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          max_wait;
    bit          rand_wait;
    int          wait_cnt;
    logic [31:0] exp_pc;
    bit          pend;
    logic [31:0] pend_addr;
    bit          stall;
    logic [31:0] st_instr;
    logic [31:0] st_pc;
    int          delivered;
    logic [31:0] watch_pc;
    bit          seen_watch;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic drive_mem();
        bus.mem_rd_dat = mem_word(bus.mem_addr);
        if (bus.mem_rd_en) begin
            if (wait_cnt == 0) begin
                bus.mem_ack = 1'b1;
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            bus.mem_ack = 1'b0;
        end
    endtask

    // Transaction-level model: the decode stage must see the architectural PC stream,
    // restarting at every redirect target, with memory requests and held outputs stable.
    task automatic tick();
        @(negedge clock);
        if (bus.mem_rd_en && bus.mem_ack)
            wait_cnt = rand_wait ? int'($urandom_range(0, max_wait)) : max_wait;
        if (reset) begin
            exp_pc = RV;
            pend   = 1'b0;
            stall  = 1'b0;
        end else begin
            if (pend) begin
                checks++;
                if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== pend_addr) begin
                    errors++;
                    $display("FAIL req_stable: rd_en=%0b addr=%h required rd_en=1 addr=%h",
                             bus.mem_rd_en, bus.mem_addr, pend_addr);
                end
            end
            if (stall) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.instruction !== st_instr || bus.instr_pc !== st_pc) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b instr=%h pc=%h required valid=1 instr=%h pc=%h",
                             bus.instr_valid, bus.instruction, bus.instr_pc, st_instr, st_pc);
                end
            end
            if (bus.instr_valid && bus.instr_pc === watch_pc) seen_watch = 1'b1;
            if (bus.instr_valid && bus.instr_ready && bus.pc_src == 2'b00) begin
                checks++;
                if (bus.instr_pc !== exp_pc || bus.instruction !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL deliver: pc=%h instr=%h required pc=%h instr=%h",
                             bus.instr_pc, bus.instruction, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            case (bus.pc_src)
                2'b01: exp_pc = bus.mepc & ~32'd3;
                2'b10: exp_pc = bus.sepc & ~32'd3;
                2'b11: exp_pc = bus.branch_target & ~32'd3;
                default: ;
            endcase
            pend      = bus.mem_rd_en && !bus.mem_ack;
            pend_addr = bus.mem_addr;
            stall     = bus.instr_valid && !bus.instr_ready && (bus.pc_src == 2'b00);
            st_instr  = bus.instruction;
            st_pc     = bus.instr_pc;
        end
        @(posedge clock);
        #1;
        drive_mem();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pc_src = 2'b00;
        seen_watch = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_ready = 1'b0;
        max_wait = 0; rand_wait = 1'b0; wait_cnt = 0;
        do_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.mem_rd_en !== 1'b0 || bus.mem_addr !== RV || bus.instr_valid !== 1'b0 ||
            bus.instruction !== 32'h13 || bus.instr_pc !== RV) begin
            errors++;
            $display("FAIL reset_values: rd_en=%0b addr=%h valid=%0b instr=%h pc=%h required 0 %h 0 00000013 %h",
                     bus.mem_rd_en, bus.mem_addr, bus.instr_valid, bus.instruction, bus.instr_pc, RV, RV);
        end
        reset = 1'b0;
        checks++;
        if (bus.mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle: rd_en=%0b required 0", bus.mem_rd_en);
        end
        tick();
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== RV) begin
            errors++;
            $display("FAIL first_request: rd_en=%0b addr=%h required 1 %h", bus.mem_rd_en, bus.mem_addr, RV);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc_e;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            pc_e = RV + 32'(4 * (i / 2));
            checks++;
            if (bus.instr_valid !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL seq_valid[%0d]: valid=%0b required %0b", i, bus.instr_valid, (i % 2) == 0);
            end else if (bus.instr_valid && (bus.instr_pc !== pc_e || bus.instruction !== mem_word(pc_e))) begin
                errors++;
                $display("FAIL seq_data[%0d]: pc=%h instr=%h required %h %h",
                         i, bus.instr_pc, bus.instruction, pc_e, mem_word(pc_e));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hp;
        logic [31:0] hi;
        int          d0;
        bus.instr_ready = 1'b0;
        tick();
        hp = bus.instr_pc;
        hi = bus.instruction;
        checks++;
        if (bus.instr_valid !== 1'b1 || hp !== 32'h100C) begin
            errors++;
            $display("FAIL bp_enter: valid=%0b pc=%h required 1 0000100c", bus.instr_valid, hp);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== hp || bus.instruction !== hi || bus.mem_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: valid=%0b pc=%h instr=%h rd_en=%0b required 1 %h %h 0",
                         i, bus.instr_valid, bus.instr_pc, bus.instruction, bus.mem_rd_en, hp, hi);
            end
        end
        d0 = delivered;
        bus.instr_ready = 1'b1;
        tick();
        checks++;
        if (delivered != d0 + 1 || bus.instr_valid !== 1'b0 || bus.mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: handshakes=%0d valid=%0b rd_en=%0b required 1 0 1",
                     delivered - d0, bus.instr_valid, bus.mem_rd_en);
        end
    endtask

    task automatic test_redirect_stale();
        max_wait = 3; rand_wait = 1'b0; wait_cnt = 3;
        bus.instr_ready = 1'b1;
        do_reset();
        watch_pc = 32'h1008;
        for (int k = 0; k < 40; k++) begin
            if (bus.mem_rd_en && bus.mem_addr == 32'h1008) break;
            tick();
        end
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h1008 || bus.mem_ack !== 1'b0) begin
            errors++;
            $display("FAIL redir_setup: rd_en=%0b addr=%h ack=%0b required 1 00001008 0",
                     bus.mem_rd_en, bus.mem_addr, bus.mem_ack);
        end
        bus.pc_src = 2'b11;
        bus.branch_target = 32'h2002;
        tick();
        bus.pc_src = 2'b00;
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h1008) begin
            errors++;
            $display("FAIL redir_drop_addr: rd_en=%0b addr=%h required 1 00001008", bus.mem_rd_en, bus.mem_addr);
        end
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_rd_en && bus.mem_addr != 32'h1008) break;
            tick();
        end
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h2000) begin
            errors++;
            $display("FAIL redir_target_req: rd_en=%0b addr=%h required 1 00002000", bus.mem_rd_en, bus.mem_addr);
        end
        for (int k = 0; k < 20; k++) begin
            if (bus.instr_valid) break;
            tick();
        end
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h2000 || seen_watch) begin
            errors++;
            $display("FAIL redir_result: valid=%0b pc=%h stale_seen=%0b required 1 00002000 0",
                     bus.instr_valid, bus.instr_pc, seen_watch);
        end
        watch_pc = 32'h0000_0002;
    endtask

    task automatic test_trap_return(input logic [1:0] src, input logic [31:0] tgt);
        int d0;
        max_wait = 0; rand_wait = 1'b0;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.instr_valid) break;
            tick();
        end
        d0 = delivered;
        bus.pc_src = src;
        bus.mepc = (src == 2'b01) ? tgt : 32'h0000_0440;
        bus.sepc = (src == 2'b10) ? tgt : 32'h0000_0880;
        bus.branch_target = 32'h0000_0cc0;
        tick();
        bus.pc_src = 2'b00;
        checks++;
        if (delivered != d0 || bus.instr_valid !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== tgt) begin
            errors++;
            $display("FAIL trap_kill[%0d]: handshakes=%0d valid=%0b rd_en=%0b addr=%h required 0 0 1 %h",
                     src, delivered - d0, bus.instr_valid, bus.mem_rd_en, bus.mem_addr, tgt);
        end
        for (int k = 0; k < 10; k++) begin
            if (bus.instr_valid) break;
            tick();
        end
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== tgt || bus.instruction !== mem_word(tgt)) begin
            errors++;
            $display("FAIL trap_next[%0d]: valid=%0b pc=%h instr=%h required 1 %h %h",
                     src, bus.instr_valid, bus.instr_pc, bus.instruction, tgt, mem_word(tgt));
        end
    endtask

    task automatic test_wrap();
        max_wait = 0; rand_wait = 1'b0;
        bus.instr_ready = 1'b1;
        bus.pc_src = 2'b11;
        bus.branch_target = 32'hFFFF_FFFF;
        tick();
        bus.pc_src = 2'b00;
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_top: rd_en=%0b addr=%h required 1 fffffffc", bus.mem_rd_en, bus.mem_addr);
        end
        for (int k = 0; k < 10; k++) begin
            if (bus.mem_rd_en && bus.mem_addr != 32'hFFFF_FFFC) break;
            tick();
        end
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_zero: rd_en=%0b addr=%h required 1 00000000", bus.mem_rd_en, bus.mem_addr);
        end
    endtask

    task automatic test_random();
        int d0;
        max_wait = 3; rand_wait = 1'b1;
        d0 = delivered;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.instr_ready   = $urandom_range(0, 1) == 1;
            bus.branch_target = $urandom;
            bus.mepc          = $urandom;
            bus.sepc          = $urandom;
            bus.pc_src        = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tick();
        end
        reset = 1'b0;
        bus.pc_src = 2'b00;
        checks++;
        if (delivered - d0 < 100) begin
            errors++;
            $display("FAIL random_progress: handshakes=%0d required at least 100", delivered - d0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.pc_src = 2'b00;
        bus.branch_target = '0;
        bus.mepc = '0;
        bus.sepc = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rd_dat = '0;
        bus.instr_ready = 1'b0;
        delivered = 0;
        watch_pc = 32'h0000_0002;
        seen_watch = 1'b0;
        exp_pc = RV;
        pend = 1'b0;
        stall = 1'b0;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_stale();
        test_trap_return(2'b01, 32'h0000_0080);
        test_trap_return(2'b10, 32'h0000_0100);
        test_wrap();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
